// File: rtl/ivector_word_deser_if.sv
interface ivector_word_deser_if #(
  parameter int unsigned PAYLOAD_WORDS = 3
);
  logic                         pipe_enq__ENA;
  logic [31:0]                  pipe_enq_v;
  logic                         pipe_enq__RDY;
  logic                         request_say__ENA;
  logic [32*PAYLOAD_WORDS-1:0]  request_say_v;
  logic                         request_say__RDY;

  modport master (
    output pipe_enq__ENA,
    output pipe_enq_v,
    output request_say__RDY,
    input  pipe_enq__RDY,
    input  request_say__ENA,
    input  request_say_v
  );

  modport slave (
    input  pipe_enq__ENA,
    input  pipe_enq_v,
    input  request_say__RDY,
    output pipe_enq__RDY,
    output request_say__ENA,
    output request_say_v
  );
endinterface

// File: rtl/ivector_word_deser.sv
module ivector_word_deser #(
  parameter logic [15:0] SAY_ID        = 16'h0000,
  parameter int unsigned PAYLOAD_WORDS = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  ivector_word_deser_if.slave   bus,
  output logic [7:0]            err_count
);
  localparam int unsigned IDX_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam int unsigned VEC_W = 32 * PAYLOAD_WORDS;

  typedef enum logic [1:0] {
    HDR,
    PAY,
    HOLD,
    DROP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [15:0]        r_drop;
  logic [VEC_W-1:0]   r_vec;
  logic [7:0]         r_err;

  logic               w_acc;
  logic               w_hdr_ok;
  logic               w_last_pay;
  logic [15:0]        w_hdr_id;
  logic [15:0]        w_hdr_len;

  assign w_hdr_id   = bus.pipe_enq_v[31:16];
  assign w_hdr_len  = bus.pipe_enq_v[15:0];
  assign w_hdr_ok   = (w_hdr_id == SAY_ID) && (w_hdr_len == 16'(PAYLOAD_WORDS));
  assign w_last_pay = (r_idx == IDX_W'(PAYLOAD_WORDS - 1));
  assign w_acc      = bus.pipe_enq__ENA && (r_state != HOLD);

  assign bus.request_say_v = r_vec;
  assign err_count         = r_err;

  always_comb begin
    w_state_nxt          = r_state;
    bus.pipe_enq__RDY    = (r_state != HOLD);
    bus.request_say__ENA = 1'b0;
    case (r_state)
      HDR: begin
        if (w_acc) begin
          if (w_hdr_ok) begin
            w_state_nxt = PAY;
          end else if (w_hdr_len != 16'd0) begin
            w_state_nxt = DROP;
          end
        end
      end
      PAY: begin
        if (w_acc && w_last_pay) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        bus.request_say__ENA = bus.request_say__RDY;
        if (bus.request_say__RDY) begin
          w_state_nxt = HDR;
        end
      end
      DROP: begin
        if (w_acc && (r_drop == 16'd1)) begin
          w_state_nxt = HDR;
        end
      end
      default: w_state_nxt = HDR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= HDR;
      r_idx   <= '0;
      r_drop  <= '0;
      r_vec   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        HDR: begin
          if (w_acc) begin
            r_idx <= '0;
            if (!w_hdr_ok) begin
              if (r_err != 8'hFF) begin
                r_err <= r_err + 8'd1;
              end
              r_drop <= w_hdr_len;
            end
          end
        end
        PAY: begin
          if (w_acc) begin
            for (int unsigned k = 0; k < PAYLOAD_WORDS; k++) begin
              if (r_idx == IDX_W'(k)) begin
                r_vec[32*k +: 32] <= bus.pipe_enq_v;
              end
            end
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DROP: begin
          if (w_acc) begin
            r_drop <= r_drop - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
